// File: rtl/gate_logic_pipe.sv
// gate_logic_pipe
// Two-stage valid/ready pipeline. It evaluates six bitwise gate functions of
// three operands and then selects one of them, or the AND or OR of all six,
// as the result.
//
// Ports
//   CLK        sole clock; all state changes on its rising edge
//   RST        synchronous, active-high reset
//   A, B, C    WIDTH-bit operands
//   OP         3-bit operation select, captured with the operands
//   IN_VALID   upstream offers a beat
//   IN_READY   block accepts a beat this cycle
//   Y          WIDTH-bit result
//   Y_ALL      AND-reduction of Y, registered with Y
//   Y_ANY      OR-reduction of Y, registered with Y
//   OUT_VALID  Y, Y_ALL and Y_ANY hold a result
//   OUT_READY  downstream takes the result this cycle
//   CNT        count of delivered results, wraps silently
module gate_logic_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [2:0]       OP,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] Y,
  output logic             Y_ALL,
  output logic             Y_ANY,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [CNT_W-1:0] CNT
);

  // Stage 1: gate vectors and the operation that goes with them
  logic [WIDTH-1:0] and_reg, or_reg, xor_reg, nor_reg, nand_reg, not_reg;
  logic [2:0]       op_reg;
  logic             s1_valid_reg;

  // Stage 2: selected result and its reductions
  logic [WIDTH-1:0] y_reg;
  logic             y_all_reg, y_any_reg;
  logic             s2_valid_reg;

  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] y_next;
  logic             s2_adv, s1_adv, in_fire, out_fire;

  // Stage 2 moves when it is empty or its result is taken. Stage 1 moves
  // when it is empty or stage 2 moves, so a full pipe still streams.
  assign out_fire = s2_valid_reg & OUT_READY;
  assign s2_adv   = ~s2_valid_reg | OUT_READY;
  assign s1_adv   = ~s1_valid_reg | s2_adv;
  assign in_fire  = IN_VALID & s1_adv;

  // Per-bit pick among the six gate outputs. v is packed
  // {NOT, NAND, NOR, XOR, OR, AND}, so OP 0..5 index it directly.
  function automatic logic pick(input logic [2:0] sel, input logic [5:0] v);
    logic r;
    case (sel)
      3'd6:    r = &v;
      3'd7:    r = |v;
      default: r = v[sel];
    endcase
    return r;
  endfunction

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign y_next[gi] = pick(op_reg, {not_reg[gi], nand_reg[gi], nor_reg[gi],
                                        xor_reg[gi], or_reg[gi], and_reg[gi]});
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_reg <= 1'b0;
      and_reg      <= '0;
      or_reg       <= '0;
      xor_reg      <= '0;
      nor_reg      <= '0;
      nand_reg     <= '0;
      not_reg      <= '0;
      op_reg       <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= IN_VALID;
      // Operands are captured only for an accepted beat
      if (IN_VALID) begin
        and_reg  <= A & B;
        or_reg   <= B | C;
        xor_reg  <= A ^ C;
        nor_reg  <= ~(A | B);
        nand_reg <= ~(A & C);
        not_reg  <= ~B;
        op_reg   <= OP;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_valid_reg <= 1'b0;
      y_reg        <= '0;
      y_all_reg    <= 1'b0;
      y_any_reg    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      // A bubble leaves the last result in place; it is simply not valid
      if (s1_valid_reg) begin
        y_reg     <= y_next;
        y_all_reg <= &y_next;
        y_any_reg <= |y_next;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_reg <= '0;
    end else if (out_fire) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign IN_READY  = s1_adv;
  assign Y         = y_reg;
  assign Y_ALL     = y_all_reg;
  assign Y_ANY     = y_any_reg;
  assign OUT_VALID = s2_valid_reg;
  assign CNT       = cnt_reg;

  // in_fire is kept as a named term for readability of the handshake
  logic unused_ok;
  assign unused_ok = in_fire;

endmodule

// File: tb/tb_gate_logic_pipe.sv
// tb_gate_logic_pipe
// Self-checking bench for gate_logic_pipe (WIDTH=8, CNT_W=4). A queue-based
// reference model tracks the beats in flight with their accept edges. Every
// cycle it predicts OUT_VALID, IN_READY, CNT and, when a result is valid,
// Y / Y_ALL / Y_ANY. Directed phases run first, then random traffic.
module tb_gate_logic_pipe;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  a = '0, b = '0, c = '0;
  logic [2:0]    op = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  y;
  logic          y_all, y_any, out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] cnt;

  gate_logic_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK(clk), .RST(rst), .A(a), .B(b), .C(c), .OP(op),
    .IN_VALID(in_valid), .IN_READY(in_ready),
    .Y(y), .Y_ALL(y_all), .Y_ANY(y_any), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .CNT(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] y;
    int           acc;
  } item_t;

  item_t        q[$];
  logic [W-1:0] dlog[$];
  int           cyc = 0;
  int           mcnt = 0;
  bit           armed = 0;
  bit           rst_prev = 0;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_y(input logic [W-1:0] ra, rb, rc, input logic [2:0] rop);
    logic [W-1:0] v[6];
    logic [W-1:0] r;
    v[0] = ra & rb;
    v[1] = rb | rc;
    v[2] = ra ^ rc;
    v[3] = ~(ra | rb);
    v[4] = ~(ra & rc);
    v[5] = ~rb;
    if (rop < 3'd6) begin
      r = v[rop];
    end else if (rop == 3'd6) begin
      r = '1;
      for (int i = 0; i < 6; i++) r &= v[i];
    end else begin
      r = '0;
      for (int i = 0; i < 6; i++) r |= v[i];
    end
    return r;
  endfunction

  // One clock cycle: drive, check the pre-edge outputs, clock, update the model.
  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step(input logic r, input logic iv, input logic [W-1:0] ai, bi, ci,
                      input logic [2:0] opi, input logic ori, output bit acc);
    bit exp_ov, exp_ir;
    rst = r; in_valid = iv; a = ai; b = bi; c = ci; op = opi; out_ready = ori;
    #1;
    exp_ov = (q.size() > 0) && (q[0].acc < cyc);
    exp_ir = (q.size() < 2) || ori;
    if (armed) begin
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      chk("cnt", 64'(cnt), 64'(mcnt % (1 << CW)));
      if (exp_ov) begin
        chk("y", 64'(y), 64'(q[0].y));
        chk("y_all", 64'(y_all), 64'(&q[0].y));
        chk("y_any", 64'(y_any), 64'(|q[0].y));
      end
      if (rst_prev) begin
        chk("rst_y", {y_all, y_any, y}, 64'd0);
      end
    end
    acc = 0;
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete();
      mcnt  = 0;
      armed = 1;
    end else begin
      if (exp_ov && ori) begin
        dlog.push_back(q[0].y);
        void'(q.pop_front());
        mcnt++;
      end
      if (iv && exp_ir) begin
        item_t it;
        it.y   = ref_y(ai, bi, ci, opi);
        it.acc = cyc;
        q.push_back(it);
        acc = 1;
      end
    end
    rst_prev = r;
    #1;
  endtask

  task automatic idle(input logic ori, input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, ori, acc);
  endtask

  task automatic do_reset();
    bit acc;
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, acc);
  endtask

  initial begin : main
    bit acc;
    int guard;
    logic [W-1:0] exp_tab[4];
    logic [2:0]   op_tab[4];
    logic [W-1:0] sa[5], sb[5], sc[5];
    logic [2:0]   sop[5];

    #1;
    do_reset();
    do_reset();

    // Four consecutive beats with fixed operands, downstream always ready
    dlog.delete();
    op_tab[0] = 3'd0; op_tab[1] = 3'd2; op_tab[2] = 3'd5; op_tab[3] = 3'd7;
    exp_tab[0] = 8'h00; exp_tab[1] = 8'hC3; exp_tab[2] = 8'hF0; exp_tab[3] = 8'hFF;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hF0, 8'h0F, 8'h33, op_tab[i], 1'b1, acc);
    idle(1'b1, 3);
    chk("burst_count", 64'(dlog.size()), 64'd4);
    for (int i = 0; i < 4 && i < dlog.size(); i++) chk("burst_y", 64'(dlog[i]), 64'(exp_tab[i]));

    // AND of all six vectors
    dlog.delete();
    step(1'b0, 1'b1, 8'hF0, 8'h0F, 8'h33, 3'd6, 1'b1, acc);
    step(1'b0, 1'b1, 8'hFF, 8'hFF, 8'h00, 3'd6, 1'b1, acc);
    idle(1'b1, 3);
    chk("and6_count", 64'(dlog.size()), 64'd2);
    for (int i = 0; i < dlog.size(); i++) chk("and6_y", 64'(dlog[i]), 64'h00);

    // Backpressure: five beats, downstream stalls 4 cycles after the first result
    do_reset();
    dlog.delete();
    for (int i = 0; i < 5; i++) begin
      sa[i] = 8'($urandom); sb[i] = 8'($urandom); sc[i] = 8'($urandom); sop[i] = 3'($urandom);
    end
    begin
      int idx = 0;
      int k = 0;
      guard = 0;
      while (idx < 5 && guard < 50) begin
        step(1'b0, 1'b1, sa[idx], sb[idx], sc[idx], sop[idx], (k < 2 || k >= 6), acc);
        if (acc) idx++;
        k++;
        guard++;
      end
      chk("stall_all_accepted", 64'(idx), 64'd5);
    end
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      idle(1'b1, 1);
      guard++;
    end
    chk("stall_drained", 64'(q.size()), 64'd0);
    chk("stall_cnt", 64'(cnt), 64'd5);
    chk("stall_count", 64'(dlog.size()), 64'd5);
    for (int i = 0; i < 5 && i < dlog.size(); i++)
      chk("stall_order", 64'(dlog[i]), 64'(ref_y(sa[i], sb[i], sc[i], sop[i])));

    // Counter wrap with a 4-bit counter: 17 deliveries ends at 1
    do_reset();
    dlog.delete();
    for (int i = 0; i < 17; i++)
      step(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 1'b1, acc);
    idle(1'b1, 3);
    chk("wrap_count", 64'(dlog.size()), 64'd17);
    chk("wrap_cnt", 64'(cnt), 64'd1);

    // Reset with both stages full and downstream stalled
    do_reset();
    dlog.delete();
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 1'b0, acc);
    chk("full_before_rst", 64'(q.size()), 64'd2);
    do_reset();
    idle(1'b1, 4);
    chk("held_discarded", 64'(dlog.size()), 64'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom),
           ($urandom_range(0, 3) != 0), acc);
    end
    idle(1'b1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
